// File: rtl/tqvp_vga_fb_param.sv
// tqvp_vga_fb_param: parametrised framebuffer peripheral for TinyQV.
// It converts the vga_timing strobes into pixel reads from a bit-packed VRAM.
// Each pixel is looked up in a 4-entry 6-bit palette and registered onto the
// VGA PMOD. It also provides CPU stall requests that wait for hblank, pixel 0
// or vblank.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   address           byte address within the peripheral
//   data_in           write data
//   data_write_n      11 none, 00 8b, 01 16b, 10 32b
//   data_read_n       same encoding; reads at 0x00/0x04/0x08 issue wait requests
//   data_out          {22'd0, y_in}
//   data_ready        low while a wait request is pending
//   blank_in          high outside the visible area
//   new_line_in       1-cycle pulse at the start of each scanline retrace
//   frame_start_in    1-cycle pulse once per frame, before the first visible line
//   hsync_in/vsync_in raw syncs, re-registered to stay aligned with rgb
//   y_in              current scanline
//   uo_out            {hsync_d, rgb[5:3], vsync_d, rgb[2:0]}
//
// Wait FSM:
//   state    | meaning
//   S_IDLE   | no request pending, data_ready high
//   S_HBLANK | waiting for a rising edge of blank_in
//   S_PIXEL0 | waiting for a visible cycle with vram_index == start
//   S_VBLANK | waiting for frame_start_in
module tqvp_vga_fb_param #(
    parameter int VRAM_BITS = 384,
    parameter int IDX_W     = 9,
    parameter int PIX_W     = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    input  logic        blank_in,
    input  logic        new_line_in,
    input  logic        frame_start_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [9:0]  y_in,
    output logic [7:0]  uo_out
);
    localparam int VRAM_BYTES = VRAM_BITS / 8;

    typedef enum logic [1:0] {S_IDLE, S_HBLANK, S_PIXEL0, S_VBLANK} wait_state_t;

    // Byte tgt is written when it falls inside the access, aligned down to its size.
    function automatic logic byte_hit(input logic [5:0] tgt, input logic [5:0] addr,
                                      input logic [1:0] wn);
        case (wn)
            2'b00:   return tgt == addr;
            2'b01:   return tgt[5:1] == addr[5:1];
            2'b10:   return tgt[5:2] == addr[5:2];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] byte_lane(input logic [5:0] tgt, input logic [1:0] wn,
                                             input logic [31:0] d);
        case (wn)
            2'b00:   return d[7:0];
            2'b01:   return tgt[0] ? d[15:8] : d[7:0];
            default: return d[{tgt[1:0], 3'b000} +: 8];
        endcase
    endfunction

    function automatic logic [IDX_W-1:0] wrap(input logic [IDX_W:0] v);
        if (v >= (IDX_W+1)'(VRAM_BITS))
            return IDX_W'(v - (IDX_W+1)'(VRAM_BITS));
        return v[IDX_W-1:0];
    endfunction

    logic [VRAM_BITS-1:0] r_vram;
    logic [5:0]           r_palette [4];
    logic [IDX_W-1:0]     r_stride, r_start, r_line_base, r_vram_index;
    logic [PIX_W-1:0]     r_x_max, r_y_max, r_px_x, r_px_y;
    logic [1:0]           r_mode;
    logic [5:0]           r_rgb;
    logic                 r_hsync, r_vsync, r_blank_d;
    wait_state_t          r_wait, w_wait_next;

    logic                 w_wr, w_wr8, w_wr16, w_wr32, w_rd, w_blank_rise;
    logic                 w_vram_we [VRAM_BYTES];
    logic [7:0]           w_vram_bd [VRAM_BYTES];
    logic                 w_pal_we  [4];
    logic [7:0]           w_pal_bd  [4];
    logic [IDX_W:0]       w_step;
    logic [IDX_W-1:0]     w_next_idx, w_next_base, w_idx_hi;
    logic [1:0]           w_cidx;

    assign w_wr8   = (data_write_n == 2'b00);
    assign w_wr16  = (data_write_n == 2'b01);
    assign w_wr32  = (data_write_n == 2'b10);
    assign w_wr    = (data_write_n != 2'b11);
    assign w_rd    = (data_read_n != 2'b11);

    always_comb begin
        for (int b = 0; b < VRAM_BYTES; b++) begin
            w_vram_we[b] = byte_hit(6'(b), address, data_write_n);
            w_vram_bd[b] = byte_lane(6'(b), data_write_n, data_in);
        end
        for (int e = 0; e < 4; e++) begin
            w_pal_we[e] = byte_hit(6'(48 + e), address, data_write_n);
            w_pal_bd[e] = byte_lane(6'(48 + e), data_write_n, data_in);
        end
    end

    // VRAM has no reset; its content after reset is undefined.
    always_ff @(posedge clk) begin
        for (int b = 0; b < VRAM_BYTES; b++)
            if (w_vram_we[b])
                r_vram[b*8 +: 8] <= w_vram_bd[b];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_palette[0] <= 6'h10;
            r_palette[1] <= 6'h0B;
            r_palette[2] <= 6'h00;
            r_palette[3] <= 6'h3F;
            r_stride     <= IDX_W'(20);
            r_start      <= '0;
            r_x_max      <= PIX_W'(51);
            r_y_max      <= PIX_W'(1);
            r_mode       <= '0;
        end else begin
            for (int e = 0; e < 4; e++)
                if (w_pal_we[e])
                    r_palette[e] <= w_pal_bd[e][5:0];
            if (w_wr && address == 6'h34)
                r_stride <= w_wr8 ? IDX_W'(data_in[7:0]) : data_in[IDX_W-1:0];
            if (w_wr32 && address == 6'h34)
                r_start <= data_in[16 +: IDX_W];
            else if (w_wr16 && address == 6'h36)
                r_start <= data_in[IDX_W-1:0];
            if ((w_wr32 || w_wr16) && address == 6'h38)
                r_x_max <= data_in[PIX_W-1:0];
            if (w_wr32 && address == 6'h38)
                r_y_max <= data_in[16 +: PIX_W];
            else if (w_wr16 && address == 6'h3A)
                r_y_max <= data_in[PIX_W-1:0];
            if (w_wr && address == 6'h3C)
                r_mode <= data_in[1:0];
        end
    end

    assign w_step      = r_mode[0] ? (IDX_W+1)'(2) : (IDX_W+1)'(1);
    assign w_next_idx  = wrap({1'b0, r_vram_index} + w_step);
    assign w_next_base = wrap({1'b0, r_line_base} + {1'b0, r_stride});
    assign w_idx_hi    = wrap({1'b0, r_vram_index} + (IDX_W+1)'(1));
    assign w_cidx      = {r_mode[0] & r_vram[w_idx_hi], r_vram[r_vram_index]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_px_x       <= '0;
            r_px_y       <= '0;
            r_line_base  <= '0;
            r_vram_index <= '0;
        end else if (frame_start_in) begin
            r_px_x       <= '0;
            r_px_y       <= '0;
            r_line_base  <= r_start;
            r_vram_index <= r_start;
        end else if (new_line_in) begin
            r_px_x <= '0;
            if (r_px_y == r_y_max) begin
                r_px_y       <= '0;
                r_line_base  <= w_next_base;
                r_vram_index <= w_next_base;
            end else begin
                r_px_y       <= r_px_y + 1'b1;
                r_vram_index <= r_line_base;
            end
        end else if (blank_in) begin
            r_px_x <= '0;
        end else if (r_px_x == r_x_max) begin
            r_px_x       <= '0;
            r_vram_index <= w_next_idx;
        end else begin
            r_px_x <= r_px_x + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rgb     <= '0;
            r_hsync   <= 1'b0;
            r_vsync   <= 1'b0;
            r_blank_d <= 1'b0;
        end else begin
            r_rgb     <= (blank_in || r_mode[1]) ? 6'h00 : r_palette[w_cidx];
            r_hsync   <= hsync_in;
            r_vsync   <= vsync_in;
            r_blank_d <= blank_in;
        end
    end

    assign uo_out       = {r_hsync, r_rgb[5:3], r_vsync, r_rgb[2:0]};
    assign data_out     = {22'd0, y_in};
    assign w_blank_rise = blank_in & ~r_blank_d;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_wait <= S_IDLE;
        else
            r_wait <= w_wait_next;
    end

    // A new request in the same cycle as a release takes precedence.
    always_comb begin
        w_wait_next = r_wait;
        case (r_wait)
            S_HBLANK: if (w_blank_rise) w_wait_next = S_IDLE;
            S_PIXEL0: if (!blank_in && r_vram_index == r_start) w_wait_next = S_IDLE;
            S_VBLANK: if (frame_start_in) w_wait_next = S_IDLE;
            default:  ;
        endcase
        if (w_rd) begin
            case (address)
                6'h00:   w_wait_next = S_HBLANK;
                6'h04:   w_wait_next = S_PIXEL0;
                6'h08:   w_wait_next = S_VBLANK;
                default: ;
            endcase
        end
        data_ready = (r_wait == S_IDLE);
    end
endmodule

// File: tb/tb_tqvp_vga_fb_param.sv
module tb_tqvp_vga_fb_param;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        blank_in;
    logic        new_line_in;
    logic        frame_start_in;
    logic        hsync_in;
    logic        vsync_in;
    logic [9:0]  y_in;
    logic [7:0]  uo_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tqvp_vga_fb_param dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .address        (address),
        .data_in        (data_in),
        .data_write_n   (data_write_n),
        .data_read_n    (data_read_n),
        .data_out       (data_out),
        .data_ready     (data_ready),
        .blank_in       (blank_in),
        .new_line_in    (new_line_in),
        .frame_start_in (frame_start_in),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .y_in           (y_in),
        .uo_out         (uo_out)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [5:0] a, input logic [1:0] wn, input logic [31:0] d);
        address      = a;
        data_in      = d;
        data_write_n = wn;
        tick();
        data_write_n = 2'b11;
    endtask

    task automatic bus_rd(input logic [5:0] a);
        address     = a;
        data_read_n = 2'b10;
        tick();
        data_read_n = 2'b11;
    endtask

    task automatic pulse_frame();
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
    endtask

    task automatic pulse_line();
        new_line_in = 1'b1;
        tick();
        new_line_in = 1'b0;
    endtask

    task automatic clear_vram();
        for (int w = 0; w < 12; w++)
            bus_wr(6'(w * 4), 2'b10, 32'h0);
    endtask

    function automatic logic [7:0] uo_exp(input logic [5:0] rgb);
        return {1'b0, rgb[5:3], 1'b0, rgb[2:0]};
    endfunction

    // Counts consecutive samples of colour c (bounded), then checks the next colour.
    task automatic run_pixel(input string tag, input logic [5:0] c, input int exp_len,
                             input logic [5:0] c_next);
        int run;
        run = 0;
        tick();
        while (run < 80 && uo_out == uo_exp(c)) begin
            run++;
            tick();
        end
        check_val({tag, "_len"}, 32'(run), 32'(exp_len));
        check_val({tag, "_next"}, 32'(uo_out), 32'(uo_exp(c_next)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        address        = '0;
        data_in        = '0;
        data_write_n   = 2'b11;
        data_read_n    = 2'b11;
        blank_in       = 1'b1;
        new_line_in    = 1'b0;
        frame_start_in = 1'b0;
        hsync_in       = 1'b0;
        vsync_in       = 1'b0;
        y_in           = 10'h123;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check_val("rst_ready", 32'(data_ready), 32'd1);
        check_val("rst_uo", 32'(uo_out), 32'h00);
        check_val("data_out", data_out, 32'h123);

        hsync_in = 1'b1;
        tick();
        check_val("hsync_pipe", 32'(uo_out), 32'h80);
        hsync_in = 1'b0;
        vsync_in = 1'b1;
        tick();
        check_val("vsync_pipe", 32'(uo_out), 32'h08);
        vsync_in = 1'b0;
        tick();

        // Reset palette, 1 bpp, 52-clock pixels
        clear_vram();
        bus_wr(6'h00, 2'b10, 32'h0000_0001);
        pulse_frame();
        blank_in = 1'b0;
        run_pixel("bpp1_px0", 6'h0B, 52, 6'h10);
        blank_in = 1'b1;
        tick();
        check_val("blank_rgb", 32'(uo_out), 32'h00);

        // 4-colour mode: palette e0=10 e1=00 e2=0B e3=3F
        bus_wr(6'h30, 2'b10, 32'h3F0B_0010);
        bus_wr(6'h3C, 2'b10, 32'h1);
        bus_wr(6'h00, 2'b10, 32'h0000_000E);
        pulse_frame();
        blank_in = 1'b0;
        tick();
        check_val("bpp2_px0", 32'(uo_out), 32'(uo_exp(6'h0B)));
        repeat (52) tick();
        check_val("bpp2_px1", 32'(uo_out), 32'(uo_exp(6'h3F)));
        repeat (52) tick();
        check_val("bpp2_px2", 32'(uo_out), 32'(uo_exp(6'h10)));
        blank_in = 1'b1;
        tick();

        // Scroll: 1-clock pixels, y_size-1 = 0, start 383, stride 20
        bus_wr(6'h3C, 2'b10, 32'h0);
        bus_wr(6'h38, 2'b10, 32'h0000_0000);
        bus_wr(6'h30, 2'b10, 32'h3F2A_0005);
        bus_wr(6'h31, 2'b00, 32'h0000_0015);     // e1 = 15 via byte write
        clear_vram();
        bus_wr(6'h00, 2'b10, 32'h0008_0002);     // bits 19, 1
        bus_wr(6'h04, 2'b01, 32'h0000_0080);     // bit 39
        bus_wr(6'h2F, 2'b00, 32'h0000_0080);     // bit 383
        bus_wr(6'h34, 2'b10, 32'h017F_0014);
        pulse_frame();
        blank_in = 1'b0;
        tick();
        check_val("scroll_383", 32'(uo_out), 32'(uo_exp(6'h15)));
        tick();
        check_val("scroll_wrap0", 32'(uo_out), 32'(uo_exp(6'h05)));
        tick();
        check_val("scroll_bit1", 32'(uo_out), 32'(uo_exp(6'h15)));
        blank_in = 1'b1;
        pulse_line();
        blank_in = 1'b0;
        tick();
        check_val("row1_bit19", 32'(uo_out), 32'(uo_exp(6'h15)));
        tick();
        check_val("row1_bit20", 32'(uo_out), 32'(uo_exp(6'h05)));
        blank_in = 1'b1;
        pulse_line();
        blank_in = 1'b0;
        tick();
        check_val("row2_bit39", 32'(uo_out), 32'(uo_exp(6'h15)));
        blank_in = 1'b1;

        // y_size-1 = 1: row repeats once before advancing
        bus_wr(6'h3A, 2'b01, 32'h0000_0001);
        pulse_frame();
        blank_in = 1'b0;
        repeat (3) tick();
        blank_in = 1'b1;
        pulse_line();
        blank_in = 1'b0;
        repeat (3) tick();
        check_val("yrep_px2", 32'(uo_out), 32'(uo_exp(6'h15)));
        blank_in = 1'b1;
        pulse_line();
        blank_in = 1'b0;
        repeat (3) tick();
        check_val("yadv_px2", 32'(uo_out), 32'(uo_exp(6'h05)));
        blank_in = 1'b1;

        // display_off
        bus_wr(6'h3C, 2'b10, 32'h2);
        pulse_frame();
        blank_in = 1'b0;
        tick();
        check_val("disp_off", 32'(uo_out), 32'h00);
        blank_in = 1'b1;
        bus_wr(6'h3C, 2'b10, 32'h0);
        tick();

        // Wait requests
        bus_rd(6'h3C);
        check_val("rd_nostall", 32'(data_ready), 32'd1);
        bus_rd(6'h00);
        check_val("hb_req", 32'(data_ready), 32'd0);
        repeat (3) tick();
        check_val("hb_level", 32'(data_ready), 32'd0);
        blank_in = 1'b0;
        tick();
        check_val("hb_low", 32'(data_ready), 32'd0);
        blank_in = 1'b1;
        tick();
        check_val("hb_rel", 32'(data_ready), 32'd1);

        bus_rd(6'h04);
        check_val("p0_req", 32'(data_ready), 32'd0);
        pulse_frame();
        check_val("p0_blank", 32'(data_ready), 32'd0);
        blank_in = 1'b0;
        tick();
        check_val("p0_rel", 32'(data_ready), 32'd1);
        blank_in = 1'b1;
        tick();

        bus_rd(6'h08);
        repeat (4) tick();
        check_val("vb_hold", 32'(data_ready), 32'd0);
        pulse_frame();
        check_val("vb_rel", 32'(data_ready), 32'd1);

        bus_rd(6'h08);
        bus_rd(6'h00);
        pulse_frame();
        check_val("replace_hold", 32'(data_ready), 32'd0);
        blank_in = 1'b0;
        tick();
        blank_in = 1'b1;
        tick();
        check_val("replace_rel", 32'(data_ready), 32'd1);

        // Reset mid-wait with non-default config loaded
        bus_wr(6'h34, 2'b00, 32'h0000_0007);
        bus_wr(6'h3A, 2'b01, 32'h0000_0000);
        bus_wr(6'h3C, 2'b10, 32'h1);
        bus_rd(6'h08);
        check_val("vb_pre_rst", 32'(data_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        check_val("rst_mid_wait", 32'(data_ready), 32'd1);
        check_val("rst_mid_uo", 32'(uo_out), 32'h00);
        rst_n = 1'b1;
        tick();

        // Defaults back: palette, x/y size, stride 20, start 0, 1 bpp
        clear_vram();
        bus_wr(6'h00, 2'b10, 32'h0010_0001);     // bits 0, 20
        pulse_frame();
        blank_in = 1'b0;
        run_pixel("rst_px0", 6'h0B, 52, 6'h10);
        blank_in = 1'b1;
        pulse_line();
        blank_in = 1'b0;
        tick();
        check_val("rst_yrep", 32'(uo_out), 32'(uo_exp(6'h0B)));
        blank_in = 1'b1;
        pulse_line();
        blank_in = 1'b0;
        tick();
        check_val("rst_stride", 32'(uo_out), 32'(uo_exp(6'h0B)));
        blank_in = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
